clk_rate_generator: RTL and testbench

//  Source side of the clock-select path: derives four square-wave rates

---
 rtl/clk_rate_generator.sv | 111 +++++++++++
 tb/tb_clk_rate_generator.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/clk_rate_generator.sv
// clk_rate_generator: derives four 50%-duty square waves (out0..out3) from
// the board clock. Each is a flop output, so it can safely feed a
// gate-level clock selector. Each channel has its own half-period counter.
// All channels share enable and the synchronous phase-clear.
// Optional feature macro: CLK_RATE_TICK_EN adds tick0..tick3. Each tick is a
// one-cycle pulse on the cycle where its out_i has just risen.
module clk_rate_generator #(
    parameter int DIV0  = 50_000_000,
    parameter int DIV1  = 25_000_000,
    parameter int DIV2  = 12_500_000,
    parameter int DIV3  = 6_250_000,
    parameter int CNT_W = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic sync_clr,
    output logic out0,
    output logic out1,
    output logic out2,
    output logic out3,
`ifdef CLK_RATE_TICK_EN
    output logic tick0,
    output logic tick1,
    output logic tick2,
    output logic tick3,
`endif
    output logic running
);

    localparam int DIVS [4] = '{DIV0, DIV1, DIV2, DIV3};

    logic [3:0] outs;
`ifdef CLK_RATE_TICK_EN
    logic [3:0] ticks;
`endif

    genvar i;
    for (i = 0; i < 4; i++) begin : g_ch
        localparam int HALF = DIVS[i] / 2;
        // Terminal count is a CNT_W-bit constant; the counter never passes
        // it, so no overflow case exists.
        localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF - 1);

        // An odd or too-small divider, or a half period that does not fit in
        // CNT_W bits, stops elaboration.
        if ((DIVS[i] % 2 != 0) || (DIVS[i] < 2) ||
            (longint'(HALF - 1) >= (longint'(1) << CNT_W))) begin : g_invalid_div
            $error("clk_rate_generator: invalid divider on channel %0d", i);
        end

        logic [CNT_W-1:0] cnt;
        logic             wave;

        // Half-period counter and output toggle; reset > sync_clr > enable > hold.
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt  <= '0;
                wave <= 1'b0;
            end else if (sync_clr) begin
                cnt  <= '0;
                wave <= 1'b0;
            end else if (enable) begin
                if (cnt == LAST) begin
                    cnt  <= '0;
                    wave <= ~wave;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end

        assign outs[i] = wave;

`ifdef CLK_RATE_TICK_EN
        logic tick_q;

        // Pulse on the same edge that takes the wave from 0 to 1.
        always_ff @(posedge clk) begin
            if (reset || sync_clr) begin
                tick_q <= 1'b0;
            end else begin
                tick_q <= enable && (cnt == LAST) && !wave;
            end
        end

        assign ticks[i] = tick_q;
`endif
    end

    // Registered status: counters are advancing and not being realigned.
    always_ff @(posedge clk) begin
        if (reset) begin
            running <= 1'b0;
        end else begin
            running <= enable & ~sync_clr;
        end
    end

    assign out0 = outs[0];
    assign out1 = outs[1];
    assign out2 = outs[2];
    assign out3 = outs[3];
`ifdef CLK_RATE_TICK_EN
    assign tick0 = ticks[0];
    assign tick1 = ticks[1];
    assign tick2 = ticks[2];
    assign tick3 = ticks[3];
`endif

endmodule

// File: tb/tb_clk_rate_generator.sv
// Directed bench for clk_rate_generator with DIV = 2,4,6,10 (half periods
// 1,2,3,5) and CNT_W = 4.
module tb_clk_rate_generator;

    logic clk = 1'b0;
    logic reset, enable, sync_clr;
    logic out0, out1, out2, out3, running;
`ifdef CLK_RATE_TICK_EN
    logic tick0, tick1, tick2, tick3;
    int   tick_cnt [4];
`endif

    int passed = 0;
    int total  = 0;
    int n      = 0;   // enabled edges since the last reset / sync_clr
    logic [3:0] held;

    clk_rate_generator #(
        .DIV0(2), .DIV1(4), .DIV2(6), .DIV3(10), .CNT_W(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .sync_clr (sync_clr),
        .out0     (out0),
        .out1     (out1),
        .out2     (out2),
        .out3     (out3),
`ifdef CLK_RATE_TICK_EN
        .tick0    (tick0),
        .tick1    (tick1),
        .tick2    (tick2),
        .tick3    (tick3),
`endif
        .running  (running)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One rising edge, then settle 1 time unit before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Square wave with half period h after k enabled edges from phase zero.
    function automatic logic [3:0] exp_outs(input int k);
        int h [4] = '{1, 2, 3, 5};
        logic [3:0] v;
        for (int c = 0; c < 4; c++) v[c] = ((k / h[c]) % 2) == 1;
        return v;
    endfunction

    function automatic logic [3:0] exp_ticks(input int k);
        int h [4] = '{1, 2, 3, 5};
        logic [3:0] v;
        for (int c = 0; c < 4; c++) v[c] = (k > 0) && (k % h[c] == 0) && (((k / h[c]) % 2) == 1);
        return v;
    endfunction

    task automatic run_enabled(input string tag, input int edges);
        for (int e = 0; e < edges; e++) begin
            step();
            n++;
            chk({tag, "_outs"}, {4'h0, out3, out2, out1, out0}, {4'h0, exp_outs(n)});
            chk({tag, "_running"}, {7'h0, running}, 8'h01);
`ifdef CLK_RATE_TICK_EN
            chk({tag, "_ticks"}, {4'h0, tick3, tick2, tick1, tick0}, {4'h0, exp_ticks(n)});
`endif
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; sync_clr = 1'b0;

        // Reset held for three cycles with enable high.
        for (int r = 0; r < 3; r++) begin
            step();
            chk("reset_outs", {4'h0, out3, out2, out1, out0}, 8'h00);
            chk("reset_running", {7'h0, running}, 8'h00);
`ifdef CLK_RATE_TICK_EN
            chk("reset_ticks", {4'h0, tick3, tick2, tick1, tick0}, 8'h00);
`endif
        end

        // Start-up: first rises after 1,2,3,5 edges.
        #1 reset = 1'b0; n = 0;
        step(); n++;
        chk("first_edge", {4'h0, out3, out2, out1, out0}, 8'h01);
        step(); n++;
        chk("second_edge", {4'h0, out3, out2, out1, out0}, 8'h02);
        step(); n++;
        chk("third_edge", {4'h0, out3, out2, out1, out0}, 8'h07);
        step(); n++;
        chk("fourth_edge", {4'h0, out3, out2, out1, out0}, 8'h04);
        step(); n++;
        chk("fifth_edge", {4'h0, out3, out2, out1, out0}, 8'h0D);
        run_enabled("freerun", 15);

        // Hold for 7 cycles: everything frozen.
        held = {out3, out2, out1, out0};
        enable = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step();
            chk("hold_outs", {4'h0, out3, out2, out1, out0}, {4'h0, held});
            chk("hold_running", {7'h0, running}, 8'h00);
`ifdef CLK_RATE_TICK_EN
            chk("hold_ticks", {4'h0, tick3, tick2, tick1, tick0}, 8'h00);
`endif
        end
        // Resume from held count (n continues, phase not lost).
        enable = 1'b1;
        run_enabled("resume", 10);

        // Synchronous phase clear for one cycle.
        sync_clr = 1'b1;
        step();
        chk("clr_outs", {4'h0, out3, out2, out1, out0}, 8'h00);
        chk("clr_running", {7'h0, running}, 8'h00);
        sync_clr = 1'b0; n = 0;
        run_enabled("after_clr", 15);
        chk("out3_high_before_reset", {7'h0, out3}, 8'h01);

        // One-cycle reset while out3 is high.
        reset = 1'b1;
        step();
        chk("midreset_outs", {4'h0, out3, out2, out1, out0}, 8'h00);
        chk("midreset_running", {7'h0, running}, 8'h00);
        reset = 1'b0; n = 0;
        run_enabled("after_reset", 10);

`ifdef CLK_RATE_TICK_EN
        // Tick totals over 60 enabled cycles after a reset.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) tick_cnt[c] = 0;
        for (int k = 0; k < 60; k++) begin
            step();
            tick_cnt[0] += int'(tick0);
            tick_cnt[1] += int'(tick1);
            tick_cnt[2] += int'(tick2);
            tick_cnt[3] += int'(tick3);
        end
        chk("tick0_count", 8'(tick_cnt[0]), 8'd30);
        chk("tick1_count", 8'(tick_cnt[1]), 8'd15);
        chk("tick2_count", 8'(tick_cnt[2]), 8'd10);
        chk("tick3_count", 8'(tick_cnt[3]), 8'd6);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
